// File: rtl/cavlc_bitstream_shifter.sv
// CAVLC bitstream front end: buffers 32-bit words and presents a 32-bit MSB-first
// window of unconsumed bits. Optional CAVLC_BITPOS_EN adds the BitPos consumed-bit counter.
module cavlc_bitstream_shifter #(
  parameter int WORD_W = 32,
  parameter int BUF_W  = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic [WORD_W-1:0] InData,
  input  logic              InValid,
  output logic              InReady,
  output logic [WORD_W-1:0] Window,
  output logic              BarrelShifterReady,
  input  logic              ShiftEn,
  input  logic [4:0]        NumShift,
`ifdef CAVLC_BITPOS_EN
  output logic [31:0]       BitPos,
`endif
  output logic              ShiftErr
);

  // Handshake: a word transfers on a rising edge where InValid & InReady;
  // a shift of NumShift bits is taken on a rising edge where ShiftEn & BarrelShifterReady.

  logic [BUF_W-1:0] data_q, data_d;
  logic [6:0]       count_q, count_d;
  logic             err_q, err_d;
  logic             shift_ok, load;
  logic [4:0]       shamt;
  logic [6:0]       rem;
  logic [BUF_W-1:0] shifted, appended;

  assign Window             = data_q[BUF_W-1 -: WORD_W];
  assign BarrelShifterReady = (count_q >= 7'd32);
  assign InReady            = !Flush && (count_q <= 7'd32);
  assign ShiftErr           = err_q;

  always_comb begin
    shift_ok = ShiftEn && BarrelShifterReady;
    load     = InValid && InReady;
    shamt    = shift_ok ? NumShift : 5'd0;
    rem      = count_q - {2'b00, shamt};
    shifted  = data_q << shamt;
    // Valid bits are left-aligned with zeros below, so the new word can be OR-ed in at rem.
    appended = {InData, {WORD_W{1'b0}}} >> rem;
    data_d   = shifted;
    count_d  = rem;
    err_d    = err_q;
    if (Flush) begin
      data_d  = '0;
      count_d = '0;
    end else begin
      if (ShiftEn && !BarrelShifterReady) err_d = 1'b1;
      if (load) begin
        data_d  = shifted | appended;
        count_d = rem + 7'd32;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      data_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

`ifdef CAVLC_BITPOS_EN
  logic [31:0] bitpos_q;
  assign BitPos = bitpos_q;

  always_ff @(posedge Clk) begin
    if (Reset || Flush) bitpos_q <= '0;
    else                bitpos_q <= bitpos_q + {27'd0, shamt};
  end
`endif

endmodule

// File: doc/cavlc_bitstream_shifter.md
Name: cavlc_bitstream_shifter

Overview:
Bitstream front end of the CAVLC decoder. Accepts 32-bit words of the coded bitstream over a valid/ready handshake and presents a 32-bit MSB-first window of the next unconsumed bits. Consumes a variable number of bits per cycle on request from the decode control FSM. Drives BarrelShifterReady to that FSM and receives its ShiftEn/NumShift.

Parameters:
WORD_W, 32, input word width and window width; fixed at 32, other values unsupported.
BUF_W, 64, internal buffer width (2*WORD_W).

Ports:
Clk  input  1  clock; all state updates on rising edge.
Reset  input  1  synchronous, active-high reset.
Flush  input  1  synchronous clear of buffered bits (new block/slice).
InData  input  32  next bitstream word; bit 31 is the earliest bit in stream order.
InValid  input  1  InData valid.
InReady  output  1  word accepted on a cycle with InValid & InReady.
Window  output  32  next 32 unconsumed bits; Window[31] is the next bit.
BarrelShifterReady  output  1  Window holds 32 valid bits.
ShiftEn  input  1  consume NumShift bits this cycle.
NumShift  input  5  bits to consume, 0..31.
ShiftErr  output  1  sticky: ShiftEn seen while BarrelShifterReady=0.

Behaviour:
- State: Buf[63:0] with valid bits left-aligned (Buf[63] is the next bit); Count[6:0], 0..64. Invariant: bits of Buf below the valid region are 0.
- Window = Buf[63:32]. BarrelShifterReady = (Count >= 32); derived from registers only.
- InReady = !Flush & (Count <= 32). Independent of ShiftEn, so there is no combinational path from the shift request to InReady.
- Shift qualifies as Sh = ShiftEn & BarrelShifterReady; shamt = Sh ? NumShift : 0.
- Load qualifies as Ld = InValid & InReady.
- Next state, evaluated in this order within one cycle:
  - R = Count - shamt.
  - B = Buf << shamt, zero-filled.
  - If Ld: B |= ({InData, 32'b0} >> R) and Count_next = R + 32. Otherwise Count_next = R.
  - R <= 32 whenever Ld, so the result never exceeds 64.
- Latency:
  - A word accepted in cycle N is visible in Window and Count in cycle N+1.
  - A shift in cycle N updates Window in cycle N+1.
  - Shift and load in the same cycle are both applied: shift first, then append.
- NumShift = 0 with Sh: no-op, legal, no error.
- ShiftEn while BarrelShifterReady = 0:
  - Buf and Count are unchanged.
  - ShiftErr is set and stays set until Reset. Flush does not clear it.
- Flush has priority over shift and load:
  - Buf <= 0, Count <= 0.
  - InReady is 0 that cycle, so no word is lost silently; the upstream source holds the word.
  - ShiftEn in a Flush cycle is ignored, with no error.
- Full: Count > 32 gives InReady = 0; the upstream source holds the word.
- Empty/partial: Count < 32 gives BarrelShifterReady = 0. Window still shows the partial bits, zero-padded below.
- Reset (synchronous, any time including mid-stream):
  - Buf = 0, Count = 0.
  - Window = 0, BarrelShifterReady = 0, InReady = 1 (when Flush = 0), ShiftErr = 0.
- No X propagation: when unqualified, InData does not affect state.

Optional Feature:
Macro CAVLC_BITPOS_EN.
- Defined:
  - Adds output BitPos[31:0], the total number of bits consumed since the last Reset or Flush.
  - BitPos increments by shamt on each qualified shift and wraps modulo 2^32.
  - Reset value is 0; Flush sets it to 0.
  - Updates with the same one-cycle latency as Window.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with no input -> BarrelShifterReady=0, InReady=1, Window=0x00000000, ShiftErr=0.
- Push 0xDEADBEEF then 0x12345678 back to back -> after the first word: Window=0xDEADBEEF, Ready=1, InReady=1. After the second: Count=64, InReady=0.
- From the above, ShiftEn with NumShift=4 -> Window=0xEADBEEF1, InReady=0. Then NumShift=28 -> Window=0x12345678, InReady=1 (Count=32). BitPos=32 if CAVLC_BITPOS_EN is defined.
- Count=32, Window=0x12345678; same cycle ShiftEn, NumShift=8, InValid with InData=0xCAFEF00D -> next Window=0x345678CA, Count=56, InReady=0.
- Count=16 (Ready=0), ShiftEn=1, NumShift=3 -> Window unchanged, ShiftErr=1. ShiftErr is still 1 after a Flush and clears only on Reset.
- Count=40, Flush=1 with InValid=1 and InData=0xAAAAAAAA -> InReady=0 that cycle. Next cycle: Window=0, Ready=0, word not accepted, BitPos=0.
